// File: rtl/mmio_router.sv
// rtl/mmio_router.sv - CPU data-bus router: region decode, sync-read return, keyboard FIFO, bus-error capture
module mmio_router #(
    parameter int NUM_REGIONS  = 6,
    parameter int PREFIX_SHIFT = 20,
    parameter int KB_REGION    = 6,
    parameter int KB_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wrdata,
    input  logic                      cpu_we,
    input  logic                      cpu_re,
    output logic [31:0]               cpu_rddata,
    output logic [31:0]               region_addr,
    output logic [31:0]               region_wrdata,
    output logic [NUM_REGIONS-1:0]    region_we,
    input  logic [NUM_REGIONS*32-1:0] region_rddata,
    input  logic [31:0]               kb_wrdata,
    input  logic                      kb_we,
    output logic                      kb_irq,
    output logic                      err_flag,
    output logic [31:0]               err_addr
);

    localparam int PFX_W = 32 - PREFIX_SHIFT;
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int PTR_W = $clog2(KB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SEL_UNM = 2'd0,
        SEL_EXT = 2'd1,
        SEL_KB  = 2'd2
    } sel_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    logic [PFX_W-1:0]        w_pfx;
    logic [PREFIX_SHIFT-1:0] w_off;
    logic                    w_is_ext;
    logic                    w_is_kb;
    logic                    w_unmapped;
    logic                    w_pop_rd;
    logic                    w_stat_rd;
    logic                    w_flush;
    logic                    w_err_clr;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop_ok;
    logic                    w_push_ok;
    logic                    w_kb_drop;
    logic [31:0]             w_head;
    logic [31:0]             w_status;
    logic [31:0]             w_kb_rdval;
    logic [31:0]             w_ext_rd;
    logic [31:0]             w_rd_mux;
    rd_state_t               w_rd_next;

    rd_state_t               r_rd_state;
    sel_t                    r_sel;
    logic [IDX_W-1:0]        r_sel_idx;
    logic [31:0]             r_kb_cap;
    logic [31:0]             r_rd_hold;
    logic [31:0]             r_fifo [KB_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic                    r_ovf;
    logic                    r_err_flag;
    logic [31:0]             r_err_addr;

    assign w_pfx      = cpu_addr[31:PREFIX_SHIFT];
    assign w_off      = cpu_addr[PREFIX_SHIFT-1:0];
    assign w_is_ext   = (w_pfx < PFX_W'(NUM_REGIONS));
    assign w_is_kb    = (w_pfx == PFX_W'(KB_REGION));
    assign w_unmapped = (cpu_re || cpu_we) && !w_is_ext && !w_is_kb;

    assign w_pop_rd  = cpu_re && w_is_kb && (w_off == PREFIX_SHIFT'(0));
    assign w_stat_rd = cpu_re && w_is_kb && (w_off == PREFIX_SHIFT'(4));
    assign w_flush   = cpu_we && w_is_kb && (w_off == PREFIX_SHIFT'(8));
    assign w_err_clr = cpu_we && w_is_kb && (w_off == PREFIX_SHIFT'(12));

    assign region_addr   = {{PFX_W{1'b0}}, w_off};
    assign region_wrdata = cpu_wrdata;

    always_comb begin
        region_we = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (cpu_we && w_is_ext && (w_pfx == PFX_W'(i))) begin
                region_we[i] = 1'b1;
            end
        end
    end

    // A pop at full frees the slot the simultaneous push needs, so both are taken.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(KB_DEPTH));
    assign w_pop_ok  = w_pop_rd && !w_empty;
    assign w_push_ok = kb_we && (!w_full || w_pop_ok) && !w_flush;
    assign w_kb_drop = kb_we && w_full && !w_pop_ok && !w_flush;
    assign w_head    = r_fifo[r_rd_ptr];
    assign w_status  = {16'b0, r_ovf, w_full, w_empty, 13'(r_count)};
    assign kb_irq    = !w_empty;

    always_comb begin
        w_kb_rdval = '0;
        if (w_pop_rd && !w_empty) begin
            w_kb_rdval = w_head;
        end else if (w_stat_rd) begin
            w_kb_rdval = w_status;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_push_ok && !w_pop_ok) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push_ok && w_pop_ok) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
            // A drop in the same edge as a status read must not be lost.
            if (w_kb_drop) begin
                r_ovf <= 1'b1;
            end else if (w_stat_rd) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= kb_wrdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err_clr) begin
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end else if (w_unmapped && !r_err_flag) begin
            r_err_flag <= 1'b1;
            r_err_addr <= cpu_addr;
        end
    end

    assign err_flag = r_err_flag;
    assign err_addr = r_err_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= SEL_UNM;
            r_sel_idx <= '0;
            r_kb_cap  <= '0;
        end else if (cpu_re) begin
            r_sel_idx <= w_is_ext ? w_pfx[IDX_W-1:0] : '0;
            r_kb_cap  <= w_kb_rdval;
            if (w_is_ext) begin
                r_sel <= SEL_EXT;
            end else if (w_is_kb) begin
                r_sel <= SEL_KB;
            end else begin
                r_sel <= SEL_UNM;
            end
        end
    end

    always_comb begin
        w_ext_rd = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (r_sel_idx == IDX_W'(i)) begin
                w_ext_rd = region_rddata[i*32 +: 32];
            end
        end
    end

    always_comb begin
        case (r_sel)
            SEL_EXT: w_rd_mux = w_ext_rd;
            SEL_KB:  w_rd_mux = r_kb_cap;
            default: w_rd_mux = '0;
        endcase
    end

    // Read data is live from the RAMs for one cycle, then frozen until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_rd_hold  <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            if (r_rd_state == RD_DATA) begin
                r_rd_hold <= w_rd_mux;
            end
        end
    end

    always_comb begin
        w_rd_next  = RD_IDLE;
        cpu_rddata = r_rd_hold;
        if (cpu_re) begin
            w_rd_next = RD_DATA;
        end
        if (r_rd_state == RD_DATA) begin
            cpu_rddata = w_rd_mux;
        end
    end

endmodule
